// File: rtl/bram_stream_reader.sv
// bram_stream_reader: strided read sequencer for the matmul byte-lane BRAM.
// Walks base_addr, base_addr+stride, ... for num_words reads, absorbs the
// one-cycle BRAM read latency in a 2-entry buffer and presents a valid/ready
// stream. Optional out_last port enabled by BRAM_STREAM_READER_LAST_EN.
module bram_stream_reader #(
    parameter int BRAM_ADDR_WIDTH = 10,
    parameter int BRAM_DATA_WIDTH = 32
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic [BRAM_ADDR_WIDTH-1:0] base_addr,
    input  logic [BRAM_ADDR_WIDTH-1:0] stride,
    input  logic [BRAM_ADDR_WIDTH:0]   num_words,
    output logic                       busy,
    output logic                       done,
    output logic [BRAM_ADDR_WIDTH-1:0] rd_addr,
    input  logic [BRAM_DATA_WIDTH-1:0] rd_data,
    output logic [BRAM_DATA_WIDTH-1:0] out_data,
    output logic                       out_valid,
    input  logic                       out_ready
`ifdef BRAM_STREAM_READER_LAST_EN
    ,
    output logic                       out_last
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [BRAM_ADDR_WIDTH:0] ONE_WORD = (BRAM_ADDR_WIDTH+1)'(1);

    state_t                       state, state_nxt;
    logic [BRAM_ADDR_WIDTH-1:0]   stride_q;
    logic [BRAM_ADDR_WIDTH:0]     remaining;
    logic                         inflight;
    logic [BRAM_DATA_WIDTH-1:0]   buf_data [2];
    logic [1:0]                   buf_count;
    logic                         head, tail;
    logic                         pop, issue, accept, empty_cmd, finish;
    logic [2:0]                   occupancy;
`ifdef BRAM_STREAM_READER_LAST_EN
    logic                         inflight_last;
    logic [1:0]                   buf_last;
`endif

    // Credit check, handshake and command decode.
    always_comb begin
        pop       = (buf_count != 2'd0) && out_ready;
        occupancy = {1'b0, buf_count} + {2'b00, inflight};
        // A read may issue if its word will have a buffer slot, counting a same-cycle pop.
        issue     = (state == RUN) && (remaining != '0) &&
                    ((occupancy < 3'd2) || (pop && (occupancy == 3'd2)));
        accept    = (state == IDLE) && start && (num_words != '0);
        empty_cmd = (state == IDLE) && start && (num_words == '0);
        finish    = (state == DRAIN) && (buf_count == 2'd1) && !inflight && pop;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (issue && (remaining == ONE_WORD)) state_nxt = DRAIN;
            DRAIN:   if (finish) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Address walk, in-flight tracking, output buffer and done pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            done        <= 1'b0;
            rd_addr     <= '0;
            stride_q    <= '0;
            remaining   <= '0;
            inflight    <= 1'b0;
            buf_data[0] <= '0;
            buf_data[1] <= '0;
            buf_count   <= 2'd0;
            head        <= 1'b0;
            tail        <= 1'b0;
`ifdef BRAM_STREAM_READER_LAST_EN
            inflight_last <= 1'b0;
            buf_last      <= 2'b00;
`endif
        end else begin
            done     <= empty_cmd || finish;
            inflight <= issue;
            if (accept) begin
                stride_q  <= stride;
                remaining <= num_words;
                rd_addr   <= base_addr;
            end else if (issue) begin
                remaining <= remaining - ONE_WORD;
                rd_addr   <= rd_addr + stride_q;
            end
            if (inflight) begin
                buf_data[tail] <= rd_data;
                tail           <= ~tail;
            end
            if (pop) head <= ~head;
            buf_count <= buf_count + {1'b0, inflight} - {1'b0, pop};
`ifdef BRAM_STREAM_READER_LAST_EN
            inflight_last <= issue && (remaining == ONE_WORD);
            if (inflight) buf_last[tail] <= inflight_last;
`endif
        end
    end

    // Stream outputs come straight from the buffer head.
    always_comb begin
        busy      = (state != IDLE);
        out_valid = (buf_count != 2'd0);
        out_data  = buf_data[head];
`ifdef BRAM_STREAM_READER_LAST_EN
        out_last  = out_valid && buf_last[head];
`endif
    end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Scoreboard bench for bram_stream_reader: commands push expected words,
// an independent monitor pops and compares on every handshake.
module tb_bram_stream_reader;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clock, reset_n, start;
    logic [AW-1:0] base_addr, stride, rd_addr;
    logic [AW:0]   num_words;
    logic          busy, done, out_valid, out_ready;
    logic [DW-1:0] rd_data, out_data;
`ifdef BRAM_STREAM_READER_LAST_EN
    logic          out_last;
`endif

    bram_stream_reader #(.BRAM_ADDR_WIDTH(AW), .BRAM_DATA_WIDTH(DW)) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .base_addr(base_addr), .stride(stride), .num_words(num_words),
        .busy(busy), .done(done), .rd_addr(rd_addr), .rd_data(rd_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
`ifdef BRAM_STREAM_READER_LAST_EN
        , .out_last(out_last)
`endif
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic [DW-1:0] mem [1<<AW];
    exp_t          q[$];
    int            tests = 0;
    int            fails = 0;
    int            npop  = 0;
    int            mode  = 0;
    int            rcyc  = 0;
    int            pat [12] = '{1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous-read BRAM model: one cycle latency.
    always @(posedge clock) rd_data <= mem[rd_addr];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // out_ready driver: always-ready, random, or fixed toggle pattern with a long stall.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            rcyc++;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 1) != 0);
                default: out_ready = (pat[rcyc % 12] != 0);
            endcase
        end
    end

    // Monitor: compare every handshake against the scoreboard, and check stall stability.
    initial begin
        logic          stall;
        logic [DW-1:0] held;
        exp_t          e;
        stall = 1'b0;
        held  = '0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    tests++;
                    if (!out_valid || out_data !== held) begin
                        fails++;
                        $display("FAIL stall_hold: valid=%0b data=%0h expected valid=1 data=%0h", out_valid, out_data, held);
                    end
                end
                if (out_valid && out_ready) begin
                    tests++;
                    if (q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_word: got %0h expected no word", out_data);
                    end else begin
                        e = q.pop_front();
                        if (out_data !== e.data) begin
                            fails++;
                            $display("FAIL word_data: got %0h expected %0h", out_data, e.data);
                        end
`ifdef BRAM_STREAM_READER_LAST_EN
                        else if (out_last !== e.last) begin
                            fails++;
                            $display("FAIL word_last: got %0b expected %0b", out_last, e.last);
                        end
`endif
                    end
                    npop++;
                end
                stall = out_valid && !out_ready;
                held  = out_data;
            end
        end
    end

    function automatic logic [AW-1:0] addr_of(input logic [AW-1:0] b, input logic [AW-1:0] s, input int i);
        int a;
        a = (int'(b) + i * int'(s)) % (1 << AW);
        return AW'(a);
    endfunction

    task automatic issue_start(input logic [AW-1:0] b, input logic [AW-1:0] s, input int n);
        exp_t e;
        @(posedge clock);
        #1;
        start     = 1'b1;
        base_addr = b;
        stride    = s;
        num_words = (AW+1)'(n);
        for (int i = 0; i < n; i++) begin
            e.data = mem[addr_of(b, s, i)];
            e.last = (i == n - 1);
            q.push_back(e);
        end
        @(posedge clock);
        #1;
        start     = 1'b0;
        base_addr = AW'($urandom);
        stride    = AW'($urandom);
        num_words = (AW+1)'($urandom);
    endtask

    task automatic run_cmd(input logic [AW-1:0] b, input logic [AW-1:0] s, input int n,
                           input int m, input bit spur);
        int c, first_v;
        bit got;
        mode = m;
        issue_start(b, s, n);
        c = 0; first_v = 0; got = 1'b0;
        while (!got && c < 400) begin
            @(negedge clock);
            c++;
            if (m == 0 && n > 0 && c <= n) chk("rd_addr_seq", 64'(rd_addr), 64'(addr_of(b, s, c - 1)));
            if (c == 1 && n > 0) chk("busy_in_run", 64'(busy), 64'd1);
            if (out_valid && first_v == 0) first_v = c;
            if (spur && n > 0 && c == 2) begin
                start     = 1'b1;
                num_words = (AW+1)'(7);
                base_addr = AW'($urandom);
            end
            if (spur && c == 3) start = 1'b0;
            if (done) got = 1'b1;
        end
        start = 1'b0;
        chk("done_seen", 64'(got), 64'd1);
        if (got) begin
            chk("busy_at_done", 64'(busy), 64'd0);
            chk("all_words_out", 64'(q.size()), 64'd0);
            if (m == 0) chk("done_cycle", 64'(c), 64'(n == 0 ? 1 : n + 3));
            if (m == 0 && n > 0) chk("first_valid_cycle", 64'(first_v), 64'd3);
            if (n == 0) chk("no_valid_empty_cmd", 64'(first_v), 64'd0);
            @(negedge clock);
            chk("done_one_cycle", 64'(done), 64'd0);
        end
        q.delete();
    endtask

    initial begin
        int n0, c;
        reset_n   = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        stride    = '0;
        num_words = '0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
        for (int i = 0; i < 4; i++) mem[i] = DW'(32'h100 + i);
        #23;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_rd_addr", 64'(rd_addr), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        run_cmd(10'h000, 10'd1, 4, 0, 1'b0);
        run_cmd(10'h002, 10'd8, 3, 0, 1'b0);
        run_cmd(10'h3FE, 10'd1, 4, 0, 1'b0);
        run_cmd(10'h005, 10'd3, 6, 2, 1'b0);
        run_cmd(10'h007, 10'd1, 0, 0, 1'b1);
        run_cmd(10'h009, 10'd2, 5, 1, 1'b1);
        run_cmd(10'h040, 10'd7, 9, 2, 1'b1);

        // Reset in the middle of a 5-word command, after two words were taken.
        mode = 0;
        n0 = npop;
        issue_start(10'h020, 10'd3, 5);
        c = 0;
        while (npop < n0 + 2 && c < 100) begin
            @(negedge clock);
            c++;
        end
        chk("two_words_before_reset", 64'(npop - n0 >= 2), 64'd1);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        q.delete();
        @(posedge clock);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        run_cmd(10'h010, 10'd5, 5, 0, 1'b0);

        for (int k = 0; k < 15; k++)
            run_cmd(AW'($urandom), AW'($urandom), $urandom_range(0, 9), $urandom_range(0, 2),
                    1'($urandom_range(0, 1)));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
